// File: rtl/fpga_itrng_nibble_feeder.sv
// ---------------------------------------------------------------------------
// fpga_itrng_nibble_feeder
//
// Purpose:
//   Buffers 32-bit entropy words written by software and feeds them to the
//   Caliptra core's internal TRNG interface as 4-bit nibbles, least
//   significant nibble first. Nibbles are only delivered while the core
//   requests entropy, with a programmable number of idle cycles between
//   consecutive nibbles.
//
// Ports:
//   core_clk      block clock
//   cptra_rst_b   asynchronous active-low reset
//   wr_en         one-cycle pulse pushing wr_data into the word FIFO
//   wr_data       32-bit entropy word
//   fifo_reset    synchronous soft clear (same effect as reset), level
//   divisor       idle cycles inserted between nibbles
//   etrng_req     core requests entropy
//   itrng_data    nibble to the core
//   itrng_valid   one-cycle strobe qualifying itrng_data
//   fifo_empty    word FIFO holds no words
//   fifo_full     word FIFO holds DEPTH words
//   fifo_level    words held, 0..DEPTH
//   overflow      sticky: a write was dropped because the FIFO was full
//   nibble_count  total nibbles delivered, wraps modulo 2^32
// ---------------------------------------------------------------------------
module fpga_itrng_nibble_feeder #(
  parameter int DEPTH = 8,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             core_clk,
  input  logic             cptra_rst_b,
  input  logic             wr_en,
  input  logic [31:0]      wr_data,
  input  logic             fifo_reset,
  input  logic [31:0]      divisor,
  input  logic             etrng_req,
  output logic [3:0]       itrng_data,
  output logic             itrng_valid,
  output logic             fifo_empty,
  output logic             fifo_full,
  output logic [LVL_W-1:0] fifo_level,
  output logic             overflow,
  output logic [31:0]      nibble_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] FULL_LVL = PW'(DEPTH);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("fpga_itrng_nibble_feeder: DEPTH must be a power of 2 and >= 2");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  // Word storage and pointers (one extra bit distinguishes full from empty)
  logic [31:0]   mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] level;
  logic [31:0]   head_word;

  // Serialiser state
  state_e        state_q, state_d;
  logic [31:0]   sh_q, sh_d;
  logic [3:0]    nib_left_q, nib_left_d;
  logic [31:0]   cnt_q, cnt_d;

  // Registered outputs
  logic          valid_q, valid_d;
  logic [3:0]    data_q, data_d;
  logic          overflow_q, overflow_d;
  logic [31:0]   nibble_count_q, nibble_count_d;

  logic          pop;
  logic          push;

  assign level      = wr_ptr_q - rd_ptr_q;
  assign fifo_empty = (level == '0);
  assign fifo_full  = (level == FULL_LVL);
  assign fifo_level = LVL_W'(level);
  assign head_word  = mem_q[rd_ptr_q[AW-1:0]];

  // A word is only taken from the FIFO when reloading in IDLE. A write into a
  // full FIFO is still accepted when the pop frees the slot in the same cycle.
  assign pop  = (state_q == ST_IDLE) && etrng_req && !fifo_empty && !fifo_reset;
  assign push = wr_en && (!fifo_full || pop) && !fifo_reset;

  always_comb begin
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    state_d        = state_q;
    sh_d           = sh_q;
    nib_left_d     = nib_left_q;
    cnt_d          = cnt_q;
    valid_d        = 1'b0;
    data_d         = data_q;
    overflow_d     = overflow_q;
    nibble_count_d = nibble_count_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (wr_en && fifo_full && !pop) begin
      overflow_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (pop) begin
          sh_d       = head_word;
          nib_left_d = 4'd8;
          state_d    = ST_SEND;
        end
      end

      ST_SEND: begin
        // With etrng_req low the partial word simply waits here.
        if (etrng_req) begin
          valid_d        = 1'b1;
          data_d         = sh_q[3:0];
          sh_d           = {4'h0, sh_q[31:4]};
          nib_left_d     = nib_left_q - 4'd1;
          nibble_count_d = nibble_count_q + 32'd1;
          if (divisor != 32'd0) begin
            cnt_d   = divisor;
            state_d = ST_GAP;
          end else if (nib_left_q == 4'd1) begin
            state_d = ST_IDLE;
          end
        end
      end

      ST_GAP: begin
        // The gap runs to completion regardless of etrng_req or divisor.
        cnt_d = cnt_q - 32'd1;
        if (cnt_q <= 32'd1) begin
          state_d = (nib_left_q != 4'd0) ? ST_SEND : ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Soft clear wins over everything else in the cycle.
    if (fifo_reset) begin
      wr_ptr_d       = '0;
      rd_ptr_d       = '0;
      state_d        = ST_IDLE;
      nib_left_d     = 4'd0;
      cnt_d          = 32'd0;
      valid_d        = 1'b0;
      data_d         = 4'h0;
      overflow_d     = 1'b0;
      nibble_count_d = 32'd0;
    end
  end

  always_ff @(posedge core_clk or negedge cptra_rst_b) begin
    if (!cptra_rst_b) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      state_q        <= ST_IDLE;
      nib_left_q     <= 4'd0;
      cnt_q          <= 32'd0;
      valid_q        <= 1'b0;
      data_q         <= 4'h0;
      overflow_q     <= 1'b0;
      nibble_count_q <= 32'd0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      state_q        <= state_d;
      nib_left_q     <= nib_left_d;
      cnt_q          <= cnt_d;
      valid_q        <= valid_d;
      data_q         <= data_d;
      overflow_q     <= overflow_d;
      nibble_count_q <= nibble_count_d;
    end
  end

  // Datapath storage carries no reset; nib_left and the pointers qualify it.
  always_ff @(posedge core_clk) begin
    sh_q <= sh_d;
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end
  end

  assign itrng_valid  = valid_q;
  assign itrng_data   = data_q;
  assign overflow     = overflow_q;
  assign nibble_count = nibble_count_q;

endmodule

// File: tb/tb_fpga_itrng_nibble_feeder.sv
module tb_fpga_itrng_nibble_feeder;
  localparam int DEPTH = 8;
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic             clk;
  logic             rst_n;
  logic             wr_en;
  logic [31:0]      wr_data;
  logic             fifo_reset;
  logic [31:0]      divisor;
  logic             etrng_req;
  logic [3:0]       itrng_data;
  logic             itrng_valid;
  logic             fifo_empty;
  logic             fifo_full;
  logic [LVL_W-1:0] fifo_level;
  logic             overflow;
  logic [31:0]      nibble_count;

  fpga_itrng_nibble_feeder #(.DEPTH(DEPTH), .LVL_W(LVL_W)) dut (
    .core_clk    (clk),
    .cptra_rst_b (rst_n),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .fifo_reset  (fifo_reset),
    .divisor     (divisor),
    .etrng_req   (etrng_req),
    .itrng_data  (itrng_data),
    .itrng_valid (itrng_valid),
    .fifo_empty  (fifo_empty),
    .fifo_full   (fifo_full),
    .fifo_level  (fifo_level),
    .overflow    (overflow),
    .nibble_count(nibble_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  logic [3:0]  exp_q[$];     // nibbles the model expects, in delivery order
  int          strobe_t[$];  // cycle stamps of observed strobes
  logic [31:0] mdl_total;    // nibbles the model expects delivered since clear

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every strobe must carry the next nibble of the queued words.
  always @(negedge clk) begin
    if (rst_n && itrng_valid) begin
      strobe_t.push_back(cyc);
      if (exp_q.size() == 0) chk("unexpected_strobe", 32'd1, 32'd0);
      else chk("nibble", 32'(itrng_data), 32'(exp_q.pop_front()));
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic expect_word(input logic [31:0] w);
    for (int i = 0; i < 8; i++) exp_q.push_back(4'((w >> (4 * i)) & 32'hF));
    mdl_total = mdl_total + 32'd8;
  endtask

  task automatic push(input logic [31:0] w, input bit acc);
    wr_en   = 1'b1;
    wr_data = w;
    if (acc) expect_word(w);
    step();
    wr_en = 1'b0;
  endtask

  task automatic wait_strobes(input int n, input int budget, input string tag);
    int seen = 0;
    for (int i = 0; i < budget && seen < n; i++) begin
      step();
      if (itrng_valid) seen++;
    end
    if (seen < n) chk(tag, 32'(seen), 32'(n));
  endtask

  task automatic count_strobes(input int cycles, output int seen);
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      step();
      if (itrng_valid) seen++;
    end
  endtask

  int req_cyc;
  int seen;
  logic [31:0] w;

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_data = '0; fifo_reset = 1'b0;
    divisor = '0; etrng_req = 1'b0; mdl_total = '0;
    step(); step();
    chk("rst_valid", 32'(itrng_valid), 32'd0);
    chk("rst_data", 32'(itrng_data), 32'd0);
    chk("rst_empty", 32'(fifo_empty), 32'd1);
    chk("rst_full", 32'(fifo_full), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_count", nibble_count, 32'd0);
    rst_n = 1'b1;
    step();

    // Back-to-back delivery, divisor 0
    strobe_t.delete();
    push(32'h7654_3210, 1'b1);
    etrng_req = 1'b1;
    req_cyc = cyc;
    wait_strobes(8, 40, "t1_timeout");
    if (strobe_t.size() == 8) begin
      chk("t1_first_latency", 32'(strobe_t[0] - req_cyc), 32'd2);
      for (int i = 1; i < 8; i++) chk("t1_spacing", 32'(strobe_t[i] - strobe_t[i-1]), 32'd1);
    end else chk("t1_strobes", 32'(strobe_t.size()), 32'd8);
    step();
    chk("t1_count", nibble_count, mdl_total);
    chk("t1_empty", 32'(fifo_empty), 32'd1);

    // divisor 3: spacing 4 within a word, 5 across the boundary
    etrng_req = 1'b0;
    divisor = 32'd3;
    push(32'hA5A5_A5A5, 1'b1);
    push(32'h0000_000F, 1'b1);
    strobe_t.delete();
    etrng_req = 1'b1;
    wait_strobes(16, 200, "t2_timeout");
    if (strobe_t.size() == 16) begin
      for (int i = 1; i < 16; i++)
        chk("t2_spacing", 32'(strobe_t[i] - strobe_t[i-1]), (i == 8) ? 32'd5 : 32'd4);
    end else chk("t2_strobes", 32'(strobe_t.size()), 32'd16);
    for (int i = 0; i < 8; i++) step();
    chk("t2_count", nibble_count, mdl_total);
    chk("t2_empty", 32'(fifo_empty), 32'd1);

    // Overflow and write-while-full-with-pop
    etrng_req = 1'b0;
    divisor = 32'd0;
    for (int i = 0; i < DEPTH + 2; i++) push($urandom, i < DEPTH);
    chk("t3_full", 32'(fifo_full), 32'd1);
    chk("t3_level", 32'(fifo_level), 32'(DEPTH));
    chk("t3_overflow", 32'(overflow), 32'd1);
    wr_en = 1'b1; wr_data = 32'hC0FF_EE11; etrng_req = 1'b1;
    expect_word(32'hC0FF_EE11);
    step();
    wr_en = 1'b0; etrng_req = 1'b0;
    step();
    chk("t3_level_pop_push", 32'(fifo_level), 32'(DEPTH));
    chk("t3_full_pop_push", 32'(fifo_full), 32'd1);
    etrng_req = 1'b1;
    wait_strobes((DEPTH + 1) * 8, 400, "t3_timeout");
    count_strobes(10, seen);
    chk("t3_no_underflow", 32'(seen), 32'd0);
    chk("t3_drained", 32'(exp_q.size()), 32'd0);
    chk("t3_empty", 32'(fifo_empty), 32'd1);
    chk("t3_count", nibble_count, mdl_total);
    chk("t3_overflow_sticky", 32'(overflow), 32'd1);
    fifo_reset = 1'b1; mdl_total = '0;
    step();
    fifo_reset = 1'b0;
    chk("t3_overflow_clr", 32'(overflow), 32'd0);
    chk("t3_count_clr", nibble_count, 32'd0);

    // etrng_req drop mid-word
    etrng_req = 1'b0;
    push(32'h8765_4321, 1'b1);
    strobe_t.delete();
    etrng_req = 1'b1;
    wait_strobes(3, 20, "t4_first3");
    etrng_req = 1'b0;
    count_strobes(20, seen);
    chk("t4_paused", 32'(seen), 32'd0);
    etrng_req = 1'b1;
    wait_strobes(5, 20, "t4_rest");
    if (strobe_t.size() == 8) chk("t4_resume_gap", 32'(strobe_t[3] - strobe_t[2]), 32'd21);
    else chk("t4_strobes", 32'(strobe_t.size()), 32'd8);
    step();
    chk("t4_count", nibble_count, mdl_total);

    // fifo_reset mid-word with words queued
    etrng_req = 1'b0;
    divisor = 32'd2;
    push(32'h1111_2222, 1'b1);
    push(32'h3333_4444, 1'b1);
    push(32'h5555_6666, 1'b1);
    push(32'h7777_8888, 1'b1);
    etrng_req = 1'b1;
    wait_strobes(3, 40, "t5_timeout");
    fifo_reset = 1'b1; exp_q.delete(); mdl_total = '0;
    step();
    fifo_reset = 1'b0;
    chk("t5_level", 32'(fifo_level), 32'd0);
    chk("t5_empty", 32'(fifo_empty), 32'd1);
    chk("t5_count", nibble_count, 32'd0);
    chk("t5_valid", 32'(itrng_valid), 32'd0);
    count_strobes(30, seen);
    chk("t5_silent", 32'(seen), 32'd0);
    push(32'h9ABC_DEF0, 1'b1);
    wait_strobes(8, 60, "t5_fresh");
    for (int i = 0; i < 6; i++) step();
    chk("t5_fresh_count", nibble_count, mdl_total);

    // Asynchronous reset mid-GAP
    etrng_req = 1'b0;
    divisor = 32'd5;
    push(32'hDEAD_BEEF, 1'b1);
    push(32'h0123_4567, 1'b1);
    push(32'h89AB_CDEF, 1'b1);
    etrng_req = 1'b1;
    wait_strobes(2, 40, "t6_timeout");
    #2;
    rst_n = 1'b0; exp_q.delete(); mdl_total = '0;
    #1;
    chk("t6_async_level", 32'(fifo_level), 32'd0);
    chk("t6_async_empty", 32'(fifo_empty), 32'd1);
    chk("t6_async_count", nibble_count, 32'd0);
    chk("t6_async_valid", 32'(itrng_valid), 32'd0);
    chk("t6_async_data", 32'(itrng_data), 32'd0);
    step();
    rst_n = 1'b1;
    count_strobes(20, seen);
    chk("t6_silent", 32'(seen), 32'd0);

    // nibble_count wrap
    etrng_req = 1'b0;
    divisor = 32'd0;
    force dut.nibble_count_d = 32'hFFFF_FFFE;
    step();
    release dut.nibble_count_d;
    mdl_total = 32'hFFFF_FFFE;
    chk("t7_preload", nibble_count, mdl_total);
    push(32'h1234_5678, 1'b1);
    etrng_req = 1'b1;
    wait_strobes(8, 30, "t7_timeout");
    step();
    chk("t7_wrap", nibble_count, 32'd6);

    // Randomized rounds against the scoreboard
    fifo_reset = 1'b1; etrng_req = 1'b0; mdl_total = '0;
    step();
    fifo_reset = 1'b0;
    for (int r = 0; r < 12; r++) begin
      int k;
      int extra;
      bit done;
      divisor = $urandom_range(0, 3);
      k = $urandom_range(1, DEPTH);
      for (int i = 0; i < k; i++) push($urandom, 1'b1);
      extra = $urandom_range(0, 4);
      done = 1'b0;
      for (int c = 0; c < 4000 && !done; c++) begin
        etrng_req = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 15) == 0) divisor = $urandom_range(0, 3);
        if (extra > 0 && $urandom_range(0, 4) == 0 && ((exp_q.size() + 7) / 8) < DEPTH) begin
          w = $urandom;
          wr_en = 1'b1; wr_data = w;
          expect_word(w);
          extra--;
        end else wr_en = 1'b0;
        step();
        wr_en = 1'b0;
        done = (exp_q.size() == 0) && (extra == 0);
      end
      if (!done) begin
        chk("rand_drain_timeout", 32'd0, 32'd1);
        exp_q.delete();
        fifo_reset = 1'b1; mdl_total = '0;
        step();
        fifo_reset = 1'b0;
      end
      etrng_req = 1'b0;
      for (int i = 0; i < 8; i++) step();
      chk("rand_empty", 32'(fifo_empty), 32'd1);
      chk("rand_count", nibble_count, mdl_total);
    end
    chk("rand_no_overflow", 32'(overflow), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
